// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, imem req/ack handshake, one-entry response buffer, branch kill state, IF/ID register.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] PC_STEP   = 16'd1,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        InstBranch,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instrD,
    output logic [15:0] pcD,
    output logic        validD,
    output logic [15:0] fetch_cnt,
    output logic [15:0] kill_cnt
);
    typedef enum logic {FETCH, KILL} fetchState_t;

    fetchState_t state;
    logic [15:0] pcF;
    logic [15:0] reqAddr;
    logic        reqPending;
    logic        bufValid;
    logic [15:0] bufInstr;
    logic [15:0] bufPc;

    logic issueNew;
    logic accept;
    logic drain;
    logic toBuffer;

    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        issueNew  = (state == FETCH) && !reqPending && !stallF && !bufValid;
        imem_req  = !reset && (reqPending || issueNew);
        imem_addr = reqPending ? reqAddr : pcF;
        accept    = imem_req && imem_ack && (state == FETCH);
        drain     = bufValid && !stallD && !flushD;
        toBuffer  = accept && !InstBranch && (stallD || bufValid);
    end

    // NOTE: sequential state uses non-blocking assignments so every decision reads pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pcF        <= RESET_PC;
            reqAddr    <= RESET_PC;
            reqPending <= 1'b0;
            bufValid   <= 1'b0;
            instrD     <= NOP_INSTR;
            pcD        <= 16'h0000;
            validD     <= 1'b0;
        end else begin
            // A raised request is frozen until acked, even across stalls and redirects.
            if (imem_req && !imem_ack) begin
                reqPending <= 1'b1;
                reqAddr    <= imem_addr;
            end else begin
                reqPending <= 1'b0;
            end

            case (state)
                FETCH: if (InstBranch && imem_req && !imem_ack) state <= KILL;
                KILL:  if (imem_ack) state <= FETCH;
            endcase

            if (InstBranch) begin
                pcF <= branch_target;
            end else if (accept) begin
                pcF <= pcF + PC_STEP;
            end

            if (InstBranch || drain) begin
                bufValid <= 1'b0;
            end else if (toBuffer) begin
                bufValid <= 1'b1;
            end

            // With decode free and nothing arriving, IF/ID turns into a bubble so nothing issues twice.
            if (flushD) begin
                instrD <= NOP_INSTR;
                pcD    <= 16'h0000;
                validD <= 1'b0;
            end else if (!stallD) begin
                if (bufValid) begin
                    instrD <= bufInstr;
                    pcD    <= bufPc;
                    validD <= 1'b1;
                end else if (accept) begin
                    instrD <= imem_rdata;
                    pcD    <= imem_addr;
                    validD <= 1'b1;
                end else begin
                    instrD <= NOP_INSTR;
                    pcD    <= 16'h0000;
                    validD <= 1'b0;
                end
            end
        end
    end

    // NOTE: the buffer payload is only read while bufValid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (toBuffer) begin
            bufInstr <= imem_rdata;
            bufPc    <= imem_addr;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetchCnt;
    logic [15:0] killCnt;
    logic        discard;
    logic        bufKill;

    always_comb begin
        discard = imem_req && imem_ack && (state == KILL);
        bufKill = InstBranch && bufValid && !drain;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchCnt <= 16'h0000;
            killCnt  <= 16'h0000;
        end else begin
            if (accept && (fetchCnt != 16'hFFFF)) fetchCnt <= fetchCnt + 16'd1;
            if ((discard || bufKill) && (killCnt != 16'hFFFF)) killCnt <= killCnt + 16'd1;
        end
    end

    assign fetch_cnt = fetchCnt;
    assign kill_cnt  = killCnt;
`else
    assign fetch_cnt = 16'h0000;
    assign kill_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a transaction-level model checked every cycle, plus directed literal expectations.
// Memory returns addr+16'h1000 and acks once a request has been held for `lat` extra cycles.
`timescale 1ns/1ps
module tb_fetch_stage;
    localparam logic [15:0] RST_PC = 16'h0010;
    localparam logic [15:0] STEP   = 16'd1;
    localparam logic [15:0] NOP    = 16'h0000;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        valid;
    } ifid_t;
    localparam ifid_t BUBBLE = '{instr: NOP, pc: 16'h0000, valid: 1'b0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stallF = 1'b0;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic        InstBranch = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instrD;
    logic [15:0] pcD;
    logic        validD;
    logic [15:0] fetch_cnt;
    logic [15:0] kill_cnt;

    int lat = 0;
    int memAge = 0;
    int errors = 0;
    int checks = 0;
    bit modelOn = 1'b0;

    fetch_stage #(.RESET_PC(RST_PC), .PC_STEP(STEP), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .InstBranch(InstBranch), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instrD(instrD), .pcD(pcD), .validD(validD), .fetch_cnt(fetch_cnt), .kill_cnt(kill_cnt)
    );

    always #5 clk = ~clk;

    assign imem_ack   = imem_req && (memAge >= lat);
    assign imem_rdata = imem_addr + 16'h1000;
    always @(posedge clk) memAge <= (imem_req && !imem_ack) ? memAge + 1 : 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
    endtask

    // Model: fetch PC, one outstanding transaction, a buffer queue and the IF/ID word.
    logic [15:0] mPc;
    logic [15:0] mOutAddr;
    bit          mOut;
    bit          mKilled;
    int          mAge;
    int          mFetch;
    int          mKill;
    ifid_t       mIfid;
    ifid_t       mBuf[$];

    function automatic bit expReq();
        return !reset && (mOut || (!stallF && mBuf.size() == 0));
    endfunction

    function automatic logic [15:0] expAddr();
        return mOut ? mOutAddr : mPc;
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    always @(posedge clk) begin : model_upd
        bit          req;
        bit          ack;
        bit          useful;
        bit          wasEmpty;
        logic [15:0] addr;
        ifid_t       word;
        if (reset) begin
            mPc     = RST_PC;
            mOut    = 1'b0;
            mKilled = 1'b0;
            mAge    = 0;
            mFetch  = 0;
            mKill   = 0;
            mIfid   = BUBBLE;
            mBuf.delete();
            modelOn = 1'b1;
        end else begin
            req      = expReq();
            addr     = expAddr();
            ack      = req && (mAge >= lat);
            useful   = req && ack && !mKilled;
            word     = '{instr: addr + 16'h1000, pc: addr, valid: 1'b1};
            wasEmpty = (mBuf.size() == 0);
            if (flushD) begin
                mIfid = BUBBLE;
            end else if (!stallD) begin
                if (!wasEmpty) mIfid = mBuf.pop_front();
                else if (useful) mIfid = word;
                else mIfid = BUBBLE;
            end
            if (InstBranch) begin
                if (mBuf.size() > 0) mKill = sat(mKill + 1);
                mBuf.delete();
                mPc = branch_target;
            end else begin
                if (useful && !(!stallD && wasEmpty)) mBuf.push_back(word);
                if (useful) mPc = mPc + STEP;
            end
            if (useful) mFetch = sat(mFetch + 1);
            if (req && ack && mKilled) mKill = sat(mKill + 1);
            if (req && !ack) begin
                if (!mOut) mOutAddr = addr;
                mOut = 1'b1;
                mAge = mAge + 1;
                if (InstBranch) mKilled = 1'b1;
            end else begin
                mOut    = 1'b0;
                mKilled = 1'b0;
                mAge    = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            check("cyc imem_req", 16'(imem_req), 16'(expReq()));
            if (expReq()) check("cyc imem_addr", imem_addr, expAddr());
            check("cyc instrD", instrD, mIfid.instr);
            check("cyc pcD", pcD, mIfid.pc);
            check("cyc validD", 16'(validD), 16'(mIfid.valid));
            check("cyc fetch_cnt", fetch_cnt, PERF ? 16'(mFetch) : 16'h0000);
            check("cyc kill_cnt", kill_cnt, PERF ? 16'(mKill) : 16'h0000);
        end
    end

    logic stallPatD [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic stallPatF [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        // Zero-wait streaming from RESET_PC
        peek();
        check("rst req", 16'(imem_req), 16'h0001);
        check("rst addr", imem_addr, 16'h0010);
        check("rst validD", 16'(validD), 16'h0000);
        check("rst instrD", instrD, NOP);
        peek();
        check("stream addr1", imem_addr, 16'h0011);
        check("stream instr0", instrD, 16'h1010);
        check("stream valid0", 16'(validD), 16'h0001);
        peek();
        check("stream addr2", imem_addr, 16'h0012);
        check("stream instr1", instrD, 16'h1011);
        // Decode stall with a response arriving into the buffer
        step(); stallD = 1'b1;
        peek();
        check("stall instr held", instrD, 16'h1012);
        check("stall addr", imem_addr, 16'h0013);
        step(); peek();
        check("buf full req", 16'(imem_req), 16'h0000);
        check("buf instr held", instrD, 16'h1012);
        step();
        step(); stallD = 1'b0;
        peek();
        check("buf drain cycle req", 16'(imem_req), 16'h0000);
        step(); peek();
        check("buf drained instr", instrD, 16'h1013);
        check("buf drained pc", pcD, 16'h0013);
        check("after drain addr", imem_addr, 16'h0014);
        step(); peek();
        check("no skip instr", instrD, 16'h1014);
        // Branch with flush, no request left pending
        step(); InstBranch = 1'b1; flushD = 1'b1; branch_target = 16'h0200;
        step(); InstBranch = 1'b0; flushD = 1'b0;
        peek();
        check("br addr", imem_addr, 16'h0200);
        check("br bubble", 16'(validD), 16'h0000);
        step(); peek();
        check("br target instr", instrD, 16'h1200);
        check("br target pc", pcD, 16'h0200);
        // Slow memory: branch one cycle into an outstanding request
        step(); stallF = 1'b1; lat = 2;
        step(); stallF = 1'b0;
        step(); InstBranch = 1'b1; branch_target = 16'h0300;
        step(); InstBranch = 1'b0;
        peek();
        check("kill req held", 16'(imem_req), 16'h0001);
        check("kill addr held", imem_addr, 16'h0202);
        step(); peek();
        check("post kill addr", imem_addr, 16'h0300);
        check("post kill cnt", kill_cnt, PERF ? 16'h0001 : 16'h0000);
        check("post kill valid", 16'(validD), 16'h0000);
        step(); step(); step(); lat = 0;
        peek();
        check("kill target instr", instrD, 16'h1300);
        // PC wrap at FFFF
        step(); InstBranch = 1'b1; flushD = 1'b1; branch_target = 16'hFFFF;
        step(); InstBranch = 1'b0; flushD = 1'b0;
        peek();
        check("wrap addr top", imem_addr, 16'hFFFF);
        step(); peek();
        check("wrap addr zero", imem_addr, 16'h0000);
        check("wrap instr", instrD, 16'h0FFF);
        // Reset while a request is pending
        step(); lat = 2;
        step(); reset = 1'b1;
        peek();
        check("reset withdraw req", 16'(imem_req), 16'h0000);
        step(); reset = 1'b0;
        peek();
        check("post reset valid", 16'(validD), 16'h0000);
        check("post reset addr", imem_addr, RST_PC);
        check("post reset fetch_cnt", fetch_cnt, 16'h0000);
        check("post reset kill_cnt", kill_cnt, 16'h0000);
        // Branch clears a full buffer
        step(); step();
        step(); lat = 0; stallD = 1'b1;
        step(); InstBranch = 1'b1; branch_target = 16'h0400;
        peek();
        check("bufkill req", 16'(imem_req), 16'h0000);
        step(); InstBranch = 1'b0; stallD = 1'b0;
        peek();
        check("bufkill addr", imem_addr, 16'h0400);
        check("bufkill cnt", kill_cnt, PERF ? 16'h0001 : 16'h0000);
        check("bufkill held instr", instrD, 16'h1010);
        step(); peek();
        check("bufkill target instr", instrD, 16'h1400);
        // Mixed stalls with one wait state
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            stallD = stallPatD[i];
            stallF = stallPatF[i];
        end
        step(); stallD = 1'b0; stallF = 1'b0;
        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
